// File: rtl/dct_transpose_buffer.sv
// Ping-pong 8x8 transpose buffer between the row and column DCT passes.
// Optional saturating drop counter enabled by DCT_TRANSPOSE_DROP_CNT_EN.
module dct_transpose_buffer #(
  parameter int unsigned DW    = 9,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef DCT_TRANSPOSE_DROP_CNT_EN
  input  logic             drop_clr,
  output logic [CNT_W-1:0] drop_cnt,
`endif
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DW-1:0]    d0,
  input  logic [DW-1:0]    d1,
  input  logic [DW-1:0]    d2,
  input  logic [DW-1:0]    d3,
  input  logic [DW-1:0]    d4,
  input  logic [DW-1:0]    d5,
  input  logic [DW-1:0]    d6,
  input  logic [DW-1:0]    d7,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DW-1:0]    q0,
  output logic [DW-1:0]    q1,
  output logic [DW-1:0]    q2,
  output logic [DW-1:0]    q3,
  output logic [DW-1:0]    q4,
  output logic [DW-1:0]    q5,
  output logic [DW-1:0]    q6,
  output logic [DW-1:0]    q7,
  output logic             out_first,
  output logic             out_last
);

  logic [DW-1:0] din [8];
  logic [DW-1:0] col [8];
  logic [DW-1:0] bank_q [2][8][8];

  logic [1:0] full_q, full_d;
  logic       wr_bank_q, wr_bank_d;
  logic [2:0] wr_row_q, wr_row_d;
  logic       rd_bank_q, rd_bank_d;
  logic [2:0] rd_col_q, rd_col_d;
  logic       wr_fire, rd_fire;

  assign din[0] = d0;
  assign din[1] = d1;
  assign din[2] = d2;
  assign din[3] = d3;
  assign din[4] = d4;
  assign din[5] = d5;
  assign din[6] = d6;
  assign din[7] = d7;

  // Both handshakes depend on registered flags only.
  assign in_ready  = !full_q[wr_bank_q];
  assign out_valid = full_q[rd_bank_q];
  assign wr_fire   = in_valid && in_ready;
  assign rd_fire   = out_valid && out_ready;

  always_comb begin
    full_d    = full_q;
    wr_bank_d = wr_bank_q;
    wr_row_d  = wr_row_q;
    rd_bank_d = rd_bank_q;
    rd_col_d  = rd_col_q;
    if (wr_fire) begin
      if (wr_row_q == 3'd7) begin
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = !wr_bank_q;
        wr_row_d          = 3'd0;
      end else begin
        wr_row_d = wr_row_q + 3'd1;
      end
    end
    // A write only targets an empty bank and a read only a full one, so the two
    // updates to full_d never touch the same bit.
    if (rd_fire) begin
      if (rd_col_q == 3'd7) begin
        full_d[rd_bank_q] = 1'b0;
        rd_bank_d         = !rd_bank_q;
        rd_col_d          = 3'd0;
      end else begin
        rd_col_d = rd_col_q + 3'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q    <= 2'b00;
      wr_bank_q <= 1'b0;
      wr_row_q  <= 3'd0;
      rd_bank_q <= 1'b0;
      rd_col_q  <= 3'd0;
    end else begin
      full_q    <= full_d;
      wr_bank_q <= wr_bank_d;
      wr_row_q  <= wr_row_d;
      rd_bank_q <= rd_bank_d;
      rd_col_q  <= rd_col_d;
    end
  end

  // Data storage is intentionally not reset.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      for (int k = 0; k < 8; k++) begin
        bank_q[wr_bank_q][wr_row_q][k] <= din[k];
      end
    end
  end

  always_comb begin
    for (int k = 0; k < 8; k++) begin
      col[k] = out_valid ? bank_q[rd_bank_q][k][rd_col_q] : '0;
    end
  end

  assign q0        = col[0];
  assign q1        = col[1];
  assign q2        = col[2];
  assign q3        = col[3];
  assign q4        = col[4];
  assign q5        = col[5];
  assign q6        = col[6];
  assign q7        = col[7];
  assign out_first = out_valid && (rd_col_q == 3'd0);
  assign out_last  = out_valid && (rd_col_q == 3'd7);

`ifdef DCT_TRANSPOSE_DROP_CNT_EN
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop_clr) begin
      drop_cnt_d = '0;
    end else if (in_valid && !in_ready && (drop_cnt_q != '1)) begin
      drop_cnt_d = drop_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt_q <= '0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_dct_transpose_buffer.sv
// Directed self-checking bench for dct_transpose_buffer.
module tb_dct_transpose_buffer;
  localparam int DW = 9;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic [DW-1:0] d [8];
  logic          in_ready, out_valid, out_first, out_last;
  logic [DW-1:0] q0, q1, q2, q3, q4, q5, q6, q7;
`ifdef DCT_TRANSPOSE_DROP_CNT_EN
  logic          drop_clr = 1'b0;
  logic [15:0]   drop_cnt;
`endif

  int total = 0;
  int bad = 0;
  logic [DW-1:0] mem [4][8][8];
  logic [8*DW-1:0] qv;

  assign qv = {q7, q6, q5, q4, q3, q2, q1, q0};

  always #5 clk = ~clk;

  dct_transpose_buffer #(.DW(DW), .CNT_W(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
`ifdef DCT_TRANSPOSE_DROP_CNT_EN
    .drop_clr  (drop_clr),
    .drop_cnt  (drop_cnt),
`endif
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .d0        (d[0]),
    .d1        (d[1]),
    .d2        (d[2]),
    .d3        (d[3]),
    .d4        (d[4]),
    .d5        (d[5]),
    .d6        (d[6]),
    .d7        (d[7]),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .q0        (q0),
    .q1        (q1),
    .q2        (q2),
    .q3        (q3),
    .q4        (q4),
    .q5        (q5),
    .q6        (q6),
    .q7        (q7),
    .out_first (out_first),
    .out_last  (out_last)
  );

  function automatic logic [8*DW-1:0] col_exp(int b, int c);
    logic [8*DW-1:0] v;
    for (int k = 0; k < 8; k++) v[k*DW +: DW] = mem[b][k][c];
    return v;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    for (int k = 0; k < 8; k++) d[k] = '0;
`ifdef DCT_TRANSPOSE_DROP_CNT_EN
    drop_clr = 1'b0;
`endif
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic fill(int b, int base, int xr);
    for (int r = 0; r < 8; r++)
      for (int k = 0; k < 8; k++) mem[b][r][k] = DW'((base + r * 8 + k) ^ xr);
  endtask

  // Sends n rows of block b starting at row r0; in_ready must be 1 for each.
  task automatic send_rows(int b, int r0, int n, string tag);
    in_valid = 1'b1;
    for (int r = r0; r < r0 + n; r++) begin
      for (int k = 0; k < 8; k++) d[k] = mem[b][r][k];
      total++;
      if (in_ready !== 1'b1) begin
        bad++;
        $display("FAIL %s in_ready row %0d: got %b want 1", tag, r, in_ready);
      end
      cyc();
    end
    in_valid = 1'b0;
  endtask

  task automatic read_cols(int b, int c0, int n, string tag);
    out_ready = 1'b1;
    for (int c = c0; c < c0 + n; c++) begin
      total++;
      if (qv !== col_exp(b, c) ||
          {out_valid, out_first, out_last} !== {1'b1, c == 0, c == 7}) begin
        bad++;
        $display("FAIL %s col %0d: got q=%h v/f/l=%b%b%b want q=%h v/f/l=1%b%b", tag, c, qv,
                 out_valid, out_first, out_last, col_exp(b, c), c == 0, c == 7);
      end
      cyc();
    end
  endtask

  task automatic check_idle(string tag);
    total++;
    if (out_valid !== 1'b0 || qv !== '0 || out_first !== 1'b0 || out_last !== 1'b0) begin
      bad++;
      $display("FAIL %s idle: got v=%b q=%h f=%b l=%b want all 0", tag, out_valid, qv,
               out_first, out_last);
    end
  endtask

  task automatic test_reset();
    do_reset();
    check_idle("reset");
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset in_ready: got %b want 1", in_ready);
    end
`ifdef DCT_TRANSPOSE_DROP_CNT_EN
    total++;
    if (drop_cnt !== 16'd0) begin
      bad++;
      $display("FAIL reset drop_cnt: got %0d want 0", drop_cnt);
    end
`endif
  endtask

  task automatic test_single_block();
    do_reset();
    fill(0, 0, 0);
    out_ready = 1'b1;
    send_rows(0, 0, 7, "single");
    check_idle("single_pre");
    send_rows(0, 7, 1, "single");
    read_cols(0, 0, 8, "single");
    check_idle("single_post");
  endtask

  task automatic test_signed();
    do_reset();
    for (int r = 0; r < 8; r++)
      for (int k = 0; k < 8; k++) mem[0][r][k] = ((r + k) % 2 == 0) ? 9'h100 : 9'h0FF;
    out_ready = 1'b1;
    send_rows(0, 0, 8, "signed");
    read_cols(0, 0, 8, "signed");
  endtask

  task automatic test_back_to_back();
    int n = 0;
    int ncol = 0;
    do_reset();
    for (int b = 0; b < 4; b++) fill(b, b * 64, 9'h155);
    out_ready = 1'b1;
    for (int i = 0; i < 60 && ncol < 32; i++) begin
      if (n < 32) begin
        in_valid = 1'b1;
        for (int k = 0; k < 8; k++) d[k] = mem[n / 8][n % 8][k];
        total++;
        if (in_ready !== 1'b1) begin
          bad++;
          $display("FAIL stream in_ready row %0d: got %b want 1", n, in_ready);
        end
        n++;
      end else begin
        in_valid = 1'b0;
      end
      if (out_valid === 1'b1) begin
        total++;
        if (qv !== col_exp(ncol / 8, ncol % 8) ||
            {out_first, out_last} !== {ncol % 8 == 0, ncol % 8 == 7}) begin
          bad++;
          $display("FAIL stream col %0d: got q=%h f/l=%b%b want q=%h", ncol, qv, out_first,
                   out_last, col_exp(ncol / 8, ncol % 8));
        end
        ncol++;
      end else if (ncol > 0) begin
        total++;
        bad++;
        $display("FAIL stream gap after col %0d: got out_valid=0 want 1", ncol);
      end
      cyc();
    end
    in_valid = 1'b0;
    total++;
    if (ncol !== 32) begin
      bad++;
      $display("FAIL stream column count: got %0d want 32", ncol);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    fill(0, 0, 0);
    fill(1, 64, 0);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int n = 0; n < 18; n++) begin
      for (int k = 0; k < 8; k++) d[k] = (n < 16) ? mem[n / 8][n % 8][k] : 9'h1AA;
      total++;
      if (in_ready !== (n < 16)) begin
        bad++;
        $display("FAIL bp in_ready row %0d: got %b want %b", n, in_ready, n < 16);
      end
      cyc();
    end
    in_valid = 1'b0;
`ifdef DCT_TRANSPOSE_DROP_CNT_EN
    total++;
    if (drop_cnt !== 16'd2) begin
      bad++;
      $display("FAIL bp drop_cnt: got %0d want 2", drop_cnt);
    end
`endif
    out_ready = 1'b1;
    for (int c = 0; c < 16; c++) begin
      total++;
      if (in_ready !== (c >= 8)) begin
        bad++;
        $display("FAIL bp in_ready read col %0d: got %b want %b", c, in_ready, c >= 8);
      end
      read_cols(c / 8, c % 8, 1, "bp");
    end
    check_idle("bp_post");
`ifdef DCT_TRANSPOSE_DROP_CNT_EN
    drop_clr = 1'b1;
    cyc();
    drop_clr = 1'b0;
    total++;
    if (drop_cnt !== 16'd0) begin
      bad++;
      $display("FAIL bp drop_clr: got %0d want 0", drop_cnt);
    end
`endif
  endtask

  task automatic test_stall();
    do_reset();
    fill(0, 256, 0);
    out_ready = 1'b1;
    send_rows(0, 0, 8, "stall");
    read_cols(0, 0, 4, "stall");
    out_ready = 1'b0;
    for (int s = 0; s < 3; s++) begin
      total++;
      if (qv !== col_exp(0, 4) || {out_valid, out_first, out_last} !== 3'b100) begin
        bad++;
        $display("FAIL stall hold %0d: got q=%h v/f/l=%b%b%b want q=%h v/f/l=100", s, qv,
                 out_valid, out_first, out_last, col_exp(0, 4));
      end
      cyc();
    end
    read_cols(0, 4, 4, "stall");
    check_idle("stall_post");
  endtask

  task automatic test_reset_mid();
    do_reset();
    fill(0, 0, 9'h0AA);
    fill(1, 64, 9'h033);
    out_ready = 1'b0;
    send_rows(0, 0, 8, "rmid");
    send_rows(1, 0, 6, "rmid");
    total++;
    if (out_valid !== 1'b1) begin
      bad++;
      $display("FAIL rmid pending out_valid: got %b want 1", out_valid);
    end
    #2;
    rst_n = 1'b0;
    #1;
    check_idle("rmid_async");
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL rmid in_ready: got %b want 1", in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    cyc();
    fill(0, 128, 9'h1C3);
    out_ready = 1'b1;
    send_rows(0, 0, 7, "rmid_new");
    check_idle("rmid_new_pre");
    send_rows(0, 7, 1, "rmid_new");
    read_cols(0, 0, 8, "rmid_new");
    check_idle("rmid_new_post");
  endtask

  initial begin
    test_reset();
    test_single_block();
    test_signed();
    test_back_to_back();
    test_backpressure();
    test_stall();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
